sdram_host_arb: RTL and testbench

Two-port host arbiter and command sequencer in front of the SDRAM controller. Shares the single `do_read`/`do_write`/`do_mode_set` command interface between two requesters (port 0, port 1) and a mode-register config request. It latches address and write data per transaction, routes read beats back to the granting port and signals completion. Sits between the system-side masters and the SDRAM controller; `ctl_idle` is the controller's registered "state == idle" flag.

---
 rtl/sdram_host_arb.sv | 241 ++++++++++++++++++++++++
 tb/tb_sdram_host_arb.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_host_arb.sv
// Two-port host arbiter and command sequencer for the SDRAM controller.
// Arbitrates between a mode-register request and two round-robin ports,
// latches the winning transaction, drives one controller command, routes
// read beats back to the granted port and pulses a completion strobe.
module sdram_host_arb #(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 16
) (
   input  logic              sys_clk,
   input  logic              sys_rst_l,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              done0,
   output logic              done1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata,
   input  logic              mode_req,
   output logic              mode_ack,
   input  logic              ctl_idle,
   input  logic              doing_refresh,
   input  logic              sd_rd_ena,
   input  logic [DATA_W-1:0] sd_rdata,
   input  logic [2:0]        modereg_burst_length,
   output logic              do_read,
   output logic              do_write,
   output logic              do_mode_set,
   output logic [ADDR_W-1:0] mp_addx,
   output logic [DATA_W-1:0] mp_wdata,
   output logic [1:0]        grant_id,
   output logic              err_beat
);

   typedef enum logic [2:0] {
      ST_ARB,
      ST_ISSUE,
      ST_HOLD,
      ST_BUSY,
      ST_DONE
   } state_t;

   localparam logic [1:0] GID_NONE = 2'd0;
   localparam logic [1:0] GID_P0   = 2'd1;
   localparam logic [1:0] GID_P1   = 2'd2;
   localparam logic [1:0] GID_MODE = 2'd3;

   state_t              state_q, state_d;
   logic                last_q, last_d;          // 1 = port1 was served last
   logic [1:0]          grant_q, grant_d;
   logic                rd_q, rd_d;              // granted transaction is a port read
   logic [ADDR_W-1:0]   mp_addx_q, mp_addx_d;
   logic [DATA_W-1:0]   mp_wdata_q, mp_wdata_d;
   logic                do_read_q, do_read_d;
   logic                do_write_q, do_write_d;
   logic                do_mode_q, do_mode_d;
   logic [3:0]          beat_cnt_q, beat_cnt_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                rvalid0_q, rvalid0_d;
   logic                rvalid1_q, rvalid1_d;
   logic                done0_q, done0_d;
   logic                done1_q, done1_d;
   logic                mode_ack_q, mode_ack_d;
   logic                err_beat_q, err_beat_d;

   logic [3:0]          exp_beats;
   logic                pick0, pick1;
   logic                beat_hit;

   // Decode the controller's burst-length code into the expected beat count.
   always_comb begin
      case (modereg_burst_length)
         3'd0:    exp_beats = 4'd1;
         3'd1:    exp_beats = 4'd2;
         3'd2:    exp_beats = 4'd4;
         default: exp_beats = 4'd8;
      endcase
   end

   // Round-robin choice between the ports and read-beat qualification.
   always_comb begin
      pick0    = req0 && (!req1 || last_q);
      pick1    = req1 && (!req0 || !last_q);
      beat_hit = rd_q && sd_rd_ena
                 && ((state_q == ST_HOLD) || (state_q == ST_BUSY))
                 && ((grant_q == GID_P0) || (grant_q == GID_P1));
   end

   // Next-state and next-output logic for the transaction sequencer.
   always_comb begin
      // NOTE: every _d gets a default first so no path leaves a variable
      // unassigned; that is what keeps this block free of inferred latches.
      state_d    = state_q;
      last_d     = last_q;
      grant_d    = grant_q;
      rd_d       = rd_q;
      mp_addx_d  = mp_addx_q;
      mp_wdata_d = mp_wdata_q;
      do_read_d  = do_read_q;
      do_write_d = do_write_q;
      do_mode_d  = do_mode_q;
      beat_cnt_d = beat_cnt_q;
      rdata_d    = rdata_q;
      err_beat_d = err_beat_q;
      rvalid0_d  = 1'b0;
      rvalid1_d  = 1'b0;
      done0_d    = 1'b0;
      done1_d    = 1'b0;
      mode_ack_d = 1'b0;

      case (state_q)
         ST_ARB: begin
            if (ctl_idle && !doing_refresh) begin
               if (mode_req) begin
                  grant_d    = GID_MODE;
                  rd_d       = 1'b0;
                  do_mode_d  = 1'b1;
                  beat_cnt_d = 4'd0;
                  state_d    = ST_ISSUE;
               end else if (pick0) begin
                  grant_d    = GID_P0;
                  rd_d       = !we0;
                  do_read_d  = !we0;
                  do_write_d = we0;
                  mp_addx_d  = addr0;
                  mp_wdata_d = wdata0;
                  beat_cnt_d = 4'd0;
                  state_d    = ST_ISSUE;
               end else if (pick1) begin
                  grant_d    = GID_P1;
                  rd_d       = !we1;
                  do_read_d  = !we1;
                  do_write_d = we1;
                  mp_addx_d  = addr1;
                  mp_wdata_d = wdata1;
                  beat_cnt_d = 4'd0;
                  state_d    = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            if (!ctl_idle) state_d = ST_HOLD;
         end
         ST_HOLD: begin
            // Command stays up through this cycle, then drops for good so
            // the controller cannot relaunch when it returns to idle.
            do_read_d  = 1'b0;
            do_write_d = 1'b0;
            do_mode_d  = 1'b0;
            state_d    = ST_BUSY;
         end
         ST_BUSY: begin
            if (ctl_idle) begin
               done0_d    = (grant_q == GID_P0);
               done1_d    = (grant_q == GID_P1);
               mode_ack_d = (grant_q == GID_MODE);
               state_d    = ST_DONE;
            end
         end
         ST_DONE: begin
            if (rd_q && (beat_cnt_q != exp_beats)) err_beat_d = 1'b1;
            if (grant_q == GID_P0) last_d = 1'b0;
            if (grant_q == GID_P1) last_d = 1'b1;
            grant_d = GID_NONE;
            rd_d    = 1'b0;
            state_d = ST_ARB;
         end
         default: state_d = ST_ARB;
      endcase

      if (beat_hit) begin
         rdata_d    = sd_rdata;
         rvalid0_d  = (grant_q == GID_P0);
         rvalid1_d  = (grant_q == GID_P1);
         beat_cnt_d = (beat_cnt_q == 4'hF) ? beat_cnt_q : beat_cnt_q + 4'd1;
      end
   end

   // State and output registers; reset returns everything to idle at once.
   always_ff @(posedge sys_clk or negedge sys_rst_l) begin
      if (!sys_rst_l) begin
         state_q    <= ST_ARB;
         last_q     <= 1'b1;
         grant_q    <= GID_NONE;
         rd_q       <= 1'b0;
         mp_addx_q  <= '0;
         mp_wdata_q <= '0;
         do_read_q  <= 1'b0;
         do_write_q <= 1'b0;
         do_mode_q  <= 1'b0;
         beat_cnt_q <= 4'd0;
         rdata_q    <= '0;
         rvalid0_q  <= 1'b0;
         rvalid1_q  <= 1'b0;
         done0_q    <= 1'b0;
         done1_q    <= 1'b0;
         mode_ack_q <= 1'b0;
         err_beat_q <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every flop samples the pre-edge
         // value of every other flop, independent of statement order.
         state_q    <= state_d;
         last_q     <= last_d;
         grant_q    <= grant_d;
         rd_q       <= rd_d;
         mp_addx_q  <= mp_addx_d;
         mp_wdata_q <= mp_wdata_d;
         do_read_q  <= do_read_d;
         do_write_q <= do_write_d;
         do_mode_q  <= do_mode_d;
         beat_cnt_q <= beat_cnt_d;
         rdata_q    <= rdata_d;
         rvalid0_q  <= rvalid0_d;
         rvalid1_q  <= rvalid1_d;
         done0_q    <= done0_d;
         done1_q    <= done1_d;
         mode_ack_q <= mode_ack_d;
         err_beat_q <= err_beat_d;
      end
   end

   assign do_read     = do_read_q;
   assign do_write    = do_write_q;
   assign do_mode_set = do_mode_q;
   assign mp_addx     = mp_addx_q;
   assign mp_wdata    = mp_wdata_q;
   assign rdata       = rdata_q;
   assign rvalid0     = rvalid0_q;
   assign rvalid1     = rvalid1_q;
   assign done0       = done0_q;
   assign done1       = done1_q;
   assign mode_ack    = mode_ack_q;
   assign grant_id    = grant_q;
   assign err_beat    = err_beat_q;

endmodule

// File: tb/tb_sdram_host_arb.sv
// Testbench for sdram_host_arb: a table of single transactions plus
// hand-written sequences for burst errors, refresh blocking, reset during
// a read and round-robin / mode-request interleaving. A small behavioural
// SDRAM controller drives ctl_idle and the read beats.
module tb_sdram_host_arb;

   localparam int ADDR_W = 20;
   localparam int DATA_W = 16;

   logic              sys_clk = 1'b0;
   logic              sys_rst_l;
   logic              req0, req1, we0, we1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic              done0, done1, rvalid0, rvalid1;
   logic [DATA_W-1:0] rdata;
   logic              mode_req, mode_ack;
   logic              ctl_idle, doing_refresh, sd_rd_ena;
   logic [DATA_W-1:0] sd_rdata;
   logic [2:0]        modereg_burst_length;
   logic              do_read, do_write, do_mode_set;
   logic [ADDR_W-1:0] mp_addx;
   logic [DATA_W-1:0] mp_wdata;
   logic [1:0]        grant_id;
   logic              err_beat;

   sdram_host_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .sys_clk(sys_clk), .sys_rst_l(sys_rst_l),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .done0(done0), .done1(done1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata(rdata), .mode_req(mode_req), .mode_ack(mode_ack),
      .ctl_idle(ctl_idle), .doing_refresh(doing_refresh),
      .sd_rd_ena(sd_rd_ena), .sd_rdata(sd_rdata),
      .modereg_burst_length(modereg_burst_length),
      .do_read(do_read), .do_write(do_write), .do_mode_set(do_mode_set),
      .mp_addx(mp_addx), .mp_wdata(mp_wdata), .grant_id(grant_id),
      .err_beat(err_beat)
   );

   always #5 sys_clk = ~sys_clk;

   int total = 0;
   int bad   = 0;

   // Controller model state.
   int            c_st = 0;       // 0 idle, 1 command seen, 2 busy
   int            c_cnt = 0;
   bit            c_read = 0;
   int            beats_to_send = 0;
   logic [15:0]   beat_base = '0;

   // Monitor counters.
   int            cyc = 0;
   int            n_do_rd, n_do_wr, n_do_md;
   int            n_done0, n_done1, n_mack, n_rv0, n_rv1;
   int            idle_cyc, done_cyc;
   logic [1:0]    gid_prev;
   logic [15:0]   rq[$];
   logic [1:0]    gq[$];

   typedef struct {
      bit          port;
      bit          we;
      logic [19:0] addr;
      logic [15:0] wdata;
      logic [2:0]  blen;
      int          nbeats;
      int          exp_gid;
      int          exp_wr;
      int          exp_rd;
      int          exp_rv;
      int          exp_err;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic clear_mon();
      n_do_rd = 0; n_do_wr = 0; n_do_md = 0;
      n_done0 = 0; n_done1 = 0; n_mack = 0; n_rv0 = 0; n_rv1 = 0;
      idle_cyc = -1; done_cyc = -1;
      gid_prev = grant_id;
      rq.delete();
      gq.delete();
   endtask

   task automatic monitor();
      if (do_read)     n_do_rd++;
      if (do_write)    n_do_wr++;
      if (do_mode_set) n_do_md++;
      if (done0)       n_done0++;
      if (done1)       n_done1++;
      if (mode_ack)    n_mack++;
      if ((done0 || done1 || mode_ack) && done_cyc < 0) done_cyc = cyc;
      if (rvalid0) begin n_rv0++; rq.push_back(rdata); end
      if (rvalid1) begin n_rv1++; rq.push_back(rdata); end
      if (gid_prev == 2'd0 && grant_id != 2'd0) gq.push_back(grant_id);
      gid_prev = grant_id;
   endtask

   // Behavioural controller: leaves idle one cycle after seeing a command,
   // delivers the read beats, then returns to idle.
   task automatic ctrl_model();
      int n;
      case (c_st)
         0: begin
            sd_rd_ena = 1'b0;
            if (do_read || do_write || do_mode_set) begin
               c_read = do_read;
               c_st   = 1;
            end
         end
         1: begin
            ctl_idle = 1'b0;
            c_cnt    = 0;
            c_st     = 2;
         end
         default: begin
            c_cnt++;
            n = c_read ? beats_to_send : 0;
            if (c_read && c_cnt <= n) begin
               sd_rd_ena = 1'b1;
               sd_rdata  = beat_base + 16'(c_cnt);
            end else begin
               sd_rd_ena = 1'b0;
            end
            if (c_cnt == n + 2) begin
               ctl_idle = 1'b1;
               idle_cyc = cyc;
               c_st     = 0;
            end
         end
      endcase
   endtask

   task automatic ctrl_reset();
      c_st = 0; c_cnt = 0; ctl_idle = 1'b1; sd_rd_ena = 1'b0;
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
      cyc++;
      monitor();
      ctrl_model();
   endtask

   task automatic start_req(input bit port, input bit we, input logic [19:0] a, input logic [15:0] d);
      if (port) begin
         we1 = we; addr1 = a; wdata1 = d; req1 = 1'b1;
      end else begin
         we0 = we; addr0 = a; wdata0 = d; req0 = 1'b1;
      end
   endtask

   task automatic wait_done(input bit port);
      bit seen;
      seen = 0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if ((port ? n_done1 : n_done0) > 0) begin
            seen = 1;
            break;
         end
      end
      check("txn_complete", 32'(seen), 32'd1);
      if (port) req1 = 1'b0; else req0 = 1'b0;
      tick();
      tick();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_do_read"},  32'(do_read), 0);
      check({tag, "_do_write"}, 32'(do_write), 0);
      check({tag, "_do_mode"},  32'(do_mode_set), 0);
      check({tag, "_done0"},    32'(done0), 0);
      check({tag, "_done1"},    32'(done1), 0);
      check({tag, "_rvalid0"},  32'(rvalid0), 0);
      check({tag, "_rvalid1"},  32'(rvalid1), 0);
      check({tag, "_mode_ack"}, 32'(mode_ack), 0);
      check({tag, "_err_beat"}, 32'(err_beat), 0);
      check({tag, "_rdata"},    32'(rdata), 0);
      check({tag, "_mp_addx"},  32'(mp_addx), 0);
      check({tag, "_mp_wdata"}, 32'(mp_wdata), 0);
      check({tag, "_grant_id"}, 32'(grant_id), 0);
   endtask

   initial begin
      logic [1:0] exp_seq[7];
      bit         reached;
      bit         mode_raised;

      vecs[0] = '{0, 1, 20'h12345, 16'hA5A5, 3'd2, 0, 1, 3, 0, 0, 0};
      vecs[1] = '{1, 0, 20'h0ABCD, 16'h1111, 3'd2, 4, 2, 0, 3, 4, 0};
      vecs[2] = '{0, 0, 20'h00001, 16'h2222, 3'd0, 1, 1, 0, 3, 1, 0};
      vecs[3] = '{1, 1, 20'hFFFFF, 16'hFFFF, 3'd2, 0, 2, 3, 0, 0, 0};
      vecs[4] = '{1, 0, 20'h80000, 16'h0000, 3'd3, 8, 2, 0, 3, 8, 0};
      vecs[5] = '{0, 0, 20'h7FFFF, 16'h5A5A, 3'd1, 2, 1, 0, 3, 2, 0};

      sys_rst_l = 1'b0;
      req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      mode_req = 0; doing_refresh = 0; sd_rdata = '0;
      modereg_burst_length = 3'd0;
      ctrl_reset();

      // Reset state.
      repeat (3) @(posedge sys_clk);
      #1;
      check_all_zero("reset");
      sys_rst_l = 1'b1;
      clear_mon();
      tick();

      // Table of single transactions.
      for (int i = 0; i < 6; i++) begin
         clear_mon();
         modereg_burst_length = vecs[i].blen;
         beats_to_send        = vecs[i].nbeats;
         beat_base            = 16'(i << 8);
         start_req(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata);
         wait_done(vecs[i].port);
         check($sformatf("v%0d_grants", i), gq.size(), 1);
         check($sformatf("v%0d_gid", i), (gq.size() > 0) ? 32'(gq[0]) : 32'd0, vecs[i].exp_gid);
         check($sformatf("v%0d_wr_cyc", i), n_do_wr, vecs[i].exp_wr);
         check($sformatf("v%0d_rd_cyc", i), n_do_rd, vecs[i].exp_rd);
         check($sformatf("v%0d_md_cyc", i), n_do_md, 0);
         check($sformatf("v%0d_done_own", i), vecs[i].port ? n_done1 : n_done0, 1);
         check($sformatf("v%0d_done_other", i), vecs[i].port ? n_done0 : n_done1, 0);
         check($sformatf("v%0d_rv_own", i), vecs[i].port ? n_rv1 : n_rv0, vecs[i].exp_rv);
         check($sformatf("v%0d_rv_other", i), vecs[i].port ? n_rv0 : n_rv1, 0);
         for (int k = 0; k < rq.size(); k++)
            check($sformatf("v%0d_rdata%0d", i, k), rq[k], 32'(beat_base + 16'(k + 1)));
         check($sformatf("v%0d_done_lat", i), done_cyc - idle_cyc, 1);
         check($sformatf("v%0d_mp_addx", i), mp_addx, vecs[i].addr);
         check($sformatf("v%0d_mp_wdata", i), mp_wdata, vecs[i].wdata);
         check($sformatf("v%0d_err", i), 32'(err_beat), vecs[i].exp_err);
         check($sformatf("v%0d_gid_idle", i), 32'(grant_id), 0);
      end

      // Burst code 2 expects 4 beats; deliver only 3.
      clear_mon();
      modereg_burst_length = 3'd2;
      beats_to_send        = 3;
      beat_base            = 16'h0700;
      start_req(0, 0, 20'h0C0DE, 16'h0);
      wait_done(0);
      check("short_rv0", n_rv0, 3);
      check("short_err", 32'(err_beat), 1);
      clear_mon();
      beats_to_send = 0;
      start_req(1, 1, 20'h00100, 16'hBEEF);
      wait_done(1);
      check("short_err_sticky", 32'(err_beat), 1);
      check("short_next_done1", n_done1, 1);

      // Refresh blocks the grant until it clears.
      clear_mon();
      doing_refresh = 1'b1;
      start_req(0, 1, 20'h00ABC, 16'h1234);
      repeat (10) tick();
      check("refresh_no_cmd", n_do_rd + n_do_wr + n_do_md, 0);
      check("refresh_no_grant", 32'(grant_id), 0);
      doing_refresh = 1'b0;
      wait_done(0);
      check("refresh_wr_cyc", n_do_wr, 3);
      check("refresh_done0", n_done0, 1);
      check("refresh_mp_addx", mp_addx, 20'h00ABC);
      check("refresh_mp_wdata", mp_wdata, 16'h1234);

      // Reset in the middle of a read burst, then clean re-grant.
      clear_mon();
      modereg_burst_length = 3'd3;
      beats_to_send        = 8;
      beat_base            = 16'h4000;
      start_req(0, 0, 20'h33333, 16'h0);
      reached = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (n_rv0 >= 2) begin reached = 1; break; end
      end
      check("midrst_beats_seen", 32'(reached), 1);
      #2;
      sys_rst_l = 1'b0;
      #1;
      check_all_zero("midrst");
      ctrl_reset();
      tick();
      check("midrst_held_gid", 32'(grant_id), 0);
      check("midrst_held_cmd", 32'(do_read), 0);
      sys_rst_l = 1'b1;
      clear_mon();
      wait_done(0);
      check("regrant_gid", (gq.size() > 0) ? 32'(gq[0]) : 32'd0, 1);
      check("regrant_rd_cyc", n_do_rd, 3);
      check("regrant_rv0", n_rv0, 8);
      check("regrant_done0", n_done0, 1);
      check("regrant_err", 32'(err_beat), 0);
      for (int k = 0; k < rq.size(); k++)
         check($sformatf("regrant_rdata%0d", k), rq[k], 32'(16'h4000 + 16'(k + 1)));

      // Round-robin with both ports held, mode request inserted mid-stream.
      sys_rst_l = 1'b0;
      tick();
      sys_rst_l = 1'b1;
      ctrl_reset();
      clear_mon();
      beats_to_send = 0;
      we0 = 1; we1 = 1; addr0 = 20'h00010; addr1 = 20'h00020;
      req0 = 1; req1 = 1;
      mode_raised = 0;
      for (int i = 0; i < 400; i++) begin
         tick();
         if (gq.size() >= 4 && !mode_raised) begin
            mode_req    = 1'b1;
            mode_raised = 1;
         end
         if (mode_ack) mode_req = 1'b0;
         if (gq.size() >= 7) break;
      end
      req0 = 0; req1 = 0;
      repeat (20) tick();
      exp_seq = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2};
      check("rr_grants", gq.size(), 7);
      for (int k = 0; k < 7; k++)
         check($sformatf("rr_gid%0d", k), (k < gq.size()) ? 32'(gq[k]) : 32'd0, 32'(exp_seq[k]));
      check("rr_mode_ack", n_mack, 1);
      check("rr_mode_cyc", n_do_md, 3);
      check("rr_done0", n_done0, 3);
      check("rr_done1", n_done1, 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
